conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl.sv | 139 +++++++++++++
 tb/tb_conv_window_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Sliding-window sequencer for a convolution engine: loads each filter
// window row by row, pulses one compute cycle, then hands off the result.
module conv_window_ctrl #(
   parameter int ADDR_W = 7
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Start,
   input  logic [2:0]        F_in,
   input  logic [ADDR_W-1:0] Img_Last,
   input  logic [1:0]        Stride,
   input  logic              Res_Ready,
   output logic [2:0]        F,
   output logic              Local_Reset,
   output logic              Load_En,
   output logic [2:0]        Load_Row,
   output logic [ADDR_W-1:0] Win_Row,
   output logic [ADDR_W-1:0] Win_Col,
   output logic              Res_Valid,
   output logic              Busy,
   output logic              Done,
   output logic              Cfg_Err
);

   typedef enum logic [2:0] {
      IDLE, LOAD, COMPUTE, RESULT, FIN
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        f_q, f_d;
   logic [2:0]        row_q, row_d;
   logic [1:0]        stride_q, stride_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [ADDR_W-1:0] wc_q, wc_d;
   logic              err_q, err_d;

   // One extra bit keeps the fit test honest when Img_Last is all ones
   logic [ADDR_W:0] last_x, col_nxt, row_nxt;

   assign last_x  = {1'b0, last_q};
   assign col_nxt = {1'b0, wc_q} + (ADDR_W+1)'(stride_q)
                  + (ADDR_W+1)'(f_q);
   assign row_nxt = {1'b0, wr_q} + (ADDR_W+1)'(stride_q)
                  + (ADDR_W+1)'(f_q);

   always_comb begin
      state_d  = state_q;
      f_d      = f_q;
      row_d    = row_q;
      stride_d = stride_q;
      last_d   = last_q;
      wr_d     = wr_q;
      wc_d     = wc_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               f_d      = F_in;
               last_d   = Img_Last;
               stride_d = (Stride == 2'd0) ? 2'd1 : Stride;
               wr_d     = '0;
               wc_d     = '0;
               row_d    = '0;
               if ((ADDR_W+1)'(F_in) > {1'b0, Img_Last}) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (row_q == f_q) begin
               row_d   = '0;
               state_d = COMPUTE;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         COMPUTE: state_d = RESULT;
         RESULT: begin
            if (Res_Ready) begin
               if (col_nxt <= last_x) begin
                  wc_d    = wc_q + ADDR_W'(stride_q);
                  state_d = LOAD;
               end else begin
                  wc_d = '0;
                  if (row_nxt <= last_x) begin
                     wr_d    = wr_q + ADDR_W'(stride_q);
                     state_d = LOAD;
                  end else begin
                     state_d = FIN;
                  end
               end
            end
         end
         FIN: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         f_q      <= '0;
         row_q    <= '0;
         stride_q <= '0;
         last_q   <= '0;
         wr_q     <= '0;
         wc_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         row_q    <= row_d;
         stride_q <= stride_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         wc_q     <= wc_d;
         err_q    <= err_d;
      end
   end

   assign F           = f_q;
   assign Load_Row    = row_q;
   assign Win_Row     = wr_q;
   assign Win_Col     = wc_q;
   assign Load_En     = (state_q == LOAD);
   assign Local_Reset = (state_q != COMPUTE);
   assign Res_Valid   = (state_q == RESULT);
   assign Busy        = (state_q != IDLE);
   assign Done        = (state_q == FIN);
   assign Cfg_Err     = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized bench for conv_window_ctrl against a window-list model.
module tb_conv_window_ctrl;
   localparam int AW = 7;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          Start = 1'b0;
   logic          Res_Ready = 1'b0;
   logic [2:0]    F_in = '0;
   logic [AW-1:0] Img_Last = '0;
   logic [1:0]    Stride = '0;
   logic [2:0]    F, Load_Row;
   logic          Local_Reset, Load_En, Res_Valid, Busy, Done, Cfg_Err;
   logic [AW-1:0] Win_Row, Win_Col;

   int n_pass = 0;
   int n_tot  = 0;
   int o_res, o_load, o_lr, o_lc, o_cyc, m_cnt;

   conv_window_ctrl #(.ADDR_W(AW)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .F_in(F_in),
      .Img_Last(Img_Last), .Stride(Stride), .Res_Ready(Res_Ready),
      .F(F), .Local_Reset(Local_Reset), .Load_En(Load_En),
      .Load_Row(Load_Row), .Win_Row(Win_Row), .Win_Col(Win_Col),
      .Res_Valid(Res_Valid), .Busy(Busy), .Done(Done),
      .Cfg_Err(Cfg_Err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_f"}, int'(F), 0);
      chk({tag, "_lrst"}, int'(Local_Reset), 1);
      chk({tag, "_load_en"}, int'(Load_En), 0);
      chk({tag, "_load_row"}, int'(Load_Row), 0);
      chk({tag, "_win_row"}, int'(Win_Row), 0);
      chk({tag, "_win_col"}, int'(Win_Col), 0);
      chk({tag, "_res_valid"}, int'(Res_Valid), 0);
      chk({tag, "_busy"}, int'(Busy), 0);
      chk({tag, "_done"}, int'(Done), 0);
      chk({tag, "_cfg_err"}, int'(Cfg_Err), 0);
   endtask

   // Model: the raster list of window origins, plus the per-window
   // timeline of F+1 load cycles, one compute cycle, then result.
   task automatic run_pass(input int fi, input int last, input int st,
                           input int hold, input int rprob,
                           input bit noise);
      int  q_r[$];
      int  q_c[$];
      int  s, ph, idx;
      bit  err, fin, rdy;
      s   = (st == 0) ? 1 : st;
      err = (fi > last);
      if (!err)
         for (int r = 0; r + fi <= last; r += s)
            for (int c = 0; c + fi <= last; c += s) begin
               q_r.push_back(r);
               q_c.push_back(c);
            end
      m_cnt  = q_r.size();
      o_res  = 0;
      o_load = 0;
      o_lr   = -1;
      o_lc   = -1;
      @(negedge CLK);
      Start    = 1'b1;
      F_in     = 3'(fi);
      Img_Last = AW'(last);
      Stride   = 2'(st);
      @(negedge CLK);
      Start    = 1'b0;
      F_in     = 3'($urandom);
      Img_Last = AW'($urandom);
      Stride   = 2'($urandom);
      ph  = 0;
      idx = 0;
      fin = 1'b0;
      for (o_cyc = 0; o_cyc < 20000 && !fin; o_cyc++) begin
         rdy = ($urandom_range(99) < rprob);
         if (Load_En) o_load++;
         chk("busy", int'(Busy), 1);
         chk("f_latched", int'(F), fi);
         if (err || idx == m_cnt) begin
            chk("done", int'(Done), 1);
            chk("cfg_err", int'(Cfg_Err), int'(err));
            chk("fin_load_en", int'(Load_En), 0);
            chk("fin_res_valid", int'(Res_Valid), 0);
            fin = 1'b1;
            rdy = 1'b0;
         end else begin
            chk("done_early", int'(Done), 0);
            chk("cfg_err_early", int'(Cfg_Err), 0);
            chk("win_row", int'(Win_Row), q_r[idx]);
            chk("win_col", int'(Win_Col), q_c[idx]);
            chk("load_en", int'(Load_En), int'(ph <= fi));
            chk("load_row", int'(Load_Row), (ph <= fi) ? ph : 0);
            chk("local_reset", int'(Local_Reset), int'(ph != fi + 1));
            chk("res_valid", int'(Res_Valid), int'(ph > fi + 1));
            if (ph > fi + 1) begin
               if (hold > 0) begin
                  rdy = 1'b0;
                  hold--;
               end
               if (rdy) begin
                  o_res++;
                  o_lr = int'(Win_Row);
                  o_lc = int'(Win_Col);
                  idx++;
                  ph = 0;
               end
            end else begin
               ph++;
            end
         end
         Res_Ready = rdy;
         Start     = (noise && !fin) ? 1'($urandom_range(1)) : 1'b0;
         @(negedge CLK);
      end
      if (!fin) chk("timeout", 0, 1);
      chk("idle_busy", int'(Busy), 0);
      chk("idle_done", int'(Done), 0);
      chk("idle_cfg_err", int'(Cfg_Err), 0);
      Res_Ready = 1'b0;
      Start     = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk_rst_outs("por");
      RST = 1'b1;

      run_pass(2, 4, 1, 0, 100, 1'b1);
      chk("basic_model_n", m_cnt, 9);
      chk("basic_results", o_res, 9);
      chk("basic_loads", o_load, 27);
      chk("basic_cycles", o_cyc, 46);
      chk("basic_last_row", o_lr, 2);
      chk("basic_last_col", o_lc, 2);

      run_pass(1, 6, 3, 0, 100, 1'b0);
      chk("s3_model_n", m_cnt, 4);
      chk("s3_results", o_res, 4);
      chk("s3_last_row", o_lr, 3);
      chk("s3_last_col", o_lc, 3);

      run_pass(1, 6, 0, 0, 70, 1'b1);
      chk("s0_model_n", m_cnt, 36);
      chk("s0_results", o_res, 36);
      chk("s0_last_col", o_lc, 5);

      run_pass(2, 4, 2, 5, 100, 1'b0);
      chk("bp_results", o_res, 4);
      chk("bp_cycles", o_cyc, 26);

      run_pass(7, 3, 1, 0, 100, 1'b1);
      chk("err_model_n", m_cnt, 0);
      chk("err_loads", o_load, 0);
      chk("err_cycles", o_cyc, 1);

      @(negedge CLK);
      Start    = 1'b1;
      F_in     = 3'd2;
      Img_Last = AW'(4);
      Stride   = 2'd1;
      @(negedge CLK);
      Start = 1'b0;
      chk("pre_rst_load_en", int'(Load_En), 1);
      @(posedge CLK);
      #2 RST = 1'b0;
      #1 chk_rst_outs("mid_rst");
      repeat (3) begin
         @(negedge CLK);
         chk("rst_hold_done", int'(Done), 0);
         chk("rst_hold_busy", int'(Busy), 0);
      end
      RST = 1'b1;

      run_pass(0, 2, 1, 0, 100, 1'b0);
      chk("fresh_results", o_res, 9);
      chk("fresh_cycles", o_cyc, 28);

      run_pass(7, 127, 3, 0, 100, 1'b0);
      chk("edge_model_n", m_cnt, 1681);
      chk("edge_results", o_res, 1681);
      chk("edge_last_row", o_lr, 120);
      chk("edge_last_col", o_lc, 120);

      repeat (6)
         run_pass($urandom_range(7), $urandom_range(12),
                  $urandom_range(3), $urandom_range(3),
                  $urandom_range(100, 30), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
